key_press_pulse: RTL and testbench

- Consumes the clean, synchronized player-key level from the two-flop synchronizer stage.
- Debounces that level and emits exactly one single-cycle press pulse per physical press. Holding the key down, contact bounce, and release each produce no additional pulses.
- The pulse drives the tug-of-war playfield logic, which moves the light one position per pulse.
- Holds off pulses while the game is not accepting input, and never replays a press that was lost while disabled.

---
 rtl/key_press_pulse.sv | 119 +++++++++++
 tb/tb_key_press_pulse.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_press_pulse.sv
// Debounced key-press detector: one registered single-cycle pulse per accepted press,
// with a registered debounced level and a busy flag while a level change is qualified.
module key_press_pulse #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic key,
   input  logic en,
   output logic press,
   output logic held,
   output logic busy
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      ARM_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      ARM_RELEASE = 2'd3
   } state_t;

   localparam logic [CW-1:0] LAST_CNT  = CW'(DEBOUNCE_CYCLES - 1);
   localparam bit            IMMEDIATE = (DEBOUNCE_CYCLES == 1);

   state_t          state_r;
   state_t          state_next_s;
   logic [CW-1:0]   cnt_r;
   logic [CW-1:0]   cnt_next_s;
   logic            press_next_s;
   logic            held_next_s;
   logic            busy_next_s;

   // Next-state, stability counter and output decode.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      press_next_s = 1'b0;
      held_next_s  = held;
      case (state_r)
         IDLE: begin
            if (key) begin
               if (IMMEDIATE) begin
                  state_next_s = PRESSED;
                  cnt_next_s   = '0;
                  held_next_s  = 1'b1;
                  press_next_s = en;
               end else begin
                  state_next_s = ARM_PRESS;
                  cnt_next_s   = CW'(1);
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         ARM_PRESS: begin
            if (!key) begin
               state_next_s = IDLE;
               cnt_next_s   = '0;
            end else if (cnt_r == LAST_CNT) begin
               // en is sampled only here; a press lost while disabled is never replayed
               state_next_s = PRESSED;
               cnt_next_s   = '0;
               held_next_s  = 1'b1;
               press_next_s = en;
            end else begin
               cnt_next_s = cnt_r + CW'(1);
            end
         end
         PRESSED: begin
            if (key) begin
               state_next_s = PRESSED;
            end else if (IMMEDIATE) begin
               state_next_s = IDLE;
               held_next_s  = 1'b0;
            end else begin
               state_next_s = ARM_RELEASE;
               cnt_next_s   = CW'(1);
            end
         end
         ARM_RELEASE: begin
            if (key) begin
               state_next_s = PRESSED;
               cnt_next_s   = '0;
            end else if (cnt_r == LAST_CNT) begin
               state_next_s = IDLE;
               cnt_next_s   = '0;
               held_next_s  = 1'b0;
            end else begin
               cnt_next_s = cnt_r + CW'(1);
            end
         end
         default: begin
            state_next_s = IDLE;
            cnt_next_s   = '0;
            held_next_s  = 1'b0;
         end
      endcase
      busy_next_s = (state_next_s == ARM_PRESS) || (state_next_s == ARM_RELEASE);
   end

   // State, counter and registered outputs; reset has priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         press   <= 1'b0;
         held    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
         press   <= press_next_s;
         held    <= held_next_s;
         busy    <= busy_next_s;
      end
   end

endmodule

// File: tb/tb_key_press_pulse.sv
// Bench for key_press_pulse: directed scenarios plus random key/en/reset traffic on a
// DEBOUNCE_CYCLES=4 and a DEBOUNCE_CYCLES=1 instance, checked against a run-length model.
module tb_key_press_pulse;

   logic clk, reset, key, en;
   logic press4, held4, busy4;
   logic press1, held1, busy1;

   int tests_run = 0;
   int failures  = 0;

   // model state: debounced level, count of consecutive samples disagreeing with it
   logic m4_h, m4_p, m4_b, m1_h, m1_p, m1_b;
   int   m4_run, m1_run;

   key_press_pulse #(.DEBOUNCE_CYCLES(4)) dut4 (
      .clk(clk), .reset(reset), .key(key), .en(en),
      .press(press4), .held(held4), .busy(busy4)
   );

   key_press_pulse #(.DEBOUNCE_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .key(key), .en(en),
      .press(press1), .held(held1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Level flips once d consecutive samples disagree with it; a press is a flip to 1 with en high.
   task automatic model_step(input int d, input logic k, input logic e, input logic r,
                             inout logic h, inout int run, output logic p, output logic b);
      p = 1'b0;
      if (r) begin
         h   = 1'b0;
         run = 0;
      end else begin
         if (k != h) run = run + 1;
         else        run = 0;
         if (run == d) begin
            h   = ~h;
            run = 0;
            p   = h & e;
         end
      end
      b = (run != 0);
   endtask

   task automatic tick(input logic k, input logic e, input logic r);
      key   = k;
      en    = e;
      reset = r;
      @(posedge clk);
      model_step(4, k, e, r, m4_h, m4_run, m4_p, m4_b);
      model_step(1, k, e, r, m1_h, m1_run, m1_p, m1_b);
      #1;
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b1, 1'b1);
      tests_run++;
      if ({press4, held4, busy4, press1, held1, busy1} !== 6'b000000) begin
         failures++;
         $display("FAIL reset got %b%b%b %b%b%b want 000 000",
                  press4, held4, busy4, press1, held1, busy1);
      end
   endtask

   task automatic test_clean_press();
      int npress = 0;
      int at     = -1;
      for (int i = 0; i < 19; i++) begin
         tick(i >= 9, 1'b1, 1'b0);
         tests_run++;
         if ({press4, held4, busy4} !== {m4_p, m4_h, m4_b}) begin
            failures++;
            $display("FAIL clean_press step %0d got p=%b h=%b b=%b want p=%b h=%b b=%b",
                     i, press4, held4, busy4, m4_p, m4_h, m4_b);
         end
         if (press4 === 1'b1) begin
            npress++;
            at = i;
         end
      end
      tests_run++;
      if (npress != 1 || at != 12) begin
         failures++;
         $display("FAIL clean_press_once got count=%0d at=%0d want count=1 at=12", npress, at);
      end
   endtask

   task automatic test_press_bounce();
      logic [6:0] seq = 7'b1111011;
      int npress = 0;
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         tick(seq[i], 1'b1, 1'b0);
         tests_run++;
         if ({press4, held4, busy4} !== {m4_p, m4_h, m4_b} || (i == 2 && busy4 !== 1'b0)) begin
            failures++;
            $display("FAIL press_bounce step %0d got p=%b h=%b b=%b want p=%b h=%b b=%b",
                     i, press4, held4, busy4, m4_p, m4_h, m4_b);
         end
         if (press4 === 1'b1) npress++;
      end
      tests_run++;
      if (npress != 1 || press4 !== 1'b1) begin
         failures++;
         $display("FAIL press_bounce_once got count=%0d last=%b want count=1 last=1", npress, press4);
      end
   endtask

   task automatic test_release_bounce();
      logic [11:0] seq = 12'b1111_0000_1100;
      int npress = 0;
      for (int i = 0; i < 12; i++) begin
         tick(seq[i], 1'b1, 1'b0);
         tests_run++;
         if ({press4, held4, busy4} !== {m4_p, m4_h, m4_b} ||
             (i <= 6 && held4 !== 1'b1) || (i >= 7 && i <= 10 && held4 !== 1'b0)) begin
            failures++;
            $display("FAIL release_bounce step %0d got p=%b h=%b b=%b want p=%b h=%b b=%b",
                     i, press4, held4, busy4, m4_p, m4_h, m4_b);
         end
         if (press4 === 1'b1) npress++;
      end
      tests_run++;
      if (npress != 1 || press4 !== 1'b1) begin
         failures++;
         $display("FAIL release_repress got count=%0d want 1", npress);
      end
   endtask

   task automatic test_en_gating();
      int npress = 0;
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) begin
         tick(1'b1, i >= 4, 1'b0);
         tests_run++;
         if ({press4, held4, busy4} !== {m4_p, m4_h, m4_b} || press4 !== 1'b0) begin
            failures++;
            $display("FAIL en_gating step %0d got p=%b h=%b b=%b want p=%b h=%b b=%b",
                     i, press4, held4, busy4, m4_p, m4_h, m4_b);
         end
      end
      tests_run++;
      if (held4 !== 1'b1) begin
         failures++;
         $display("FAIL en_gating_held got %b want 1", held4);
      end
      for (int i = 0; i < 9; i++) begin
         tick(i >= 5, 1'b1, 1'b0);
         if (press4 === 1'b1) npress++;
      end
      tests_run++;
      if (npress != 1 || press4 !== 1'b1) begin
         failures++;
         $display("FAIL en_gating_repress got count=%0d want 1", npress);
      end
   endtask

   task automatic test_reset_mid_hold();
      tick(1'b1, 1'b1, 1'b1);
      tests_run++;
      if ({press4, held4, busy4} !== 3'b000) begin
         failures++;
         $display("FAIL reset_mid_hold got p=%b h=%b b=%b want 000", press4, held4, busy4);
      end
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 1'b1, 1'b0);
         tests_run++;
         if ({press4, held4, busy4} !== {m4_p, m4_h, m4_b} || press4 !== (i == 3)) begin
            failures++;
            $display("FAIL reset_refire step %0d got p=%b h=%b b=%b want p=%b h=%b b=%b",
                     i, press4, held4, busy4, m4_p, m4_h, m4_b);
         end
      end
   endtask

   task automatic test_immediate();
      logic [4:0] seq    = 5'b10110;
      logic [4:0] exp_p  = 5'b10010;
      tick(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick(seq[i], 1'b1, 1'b0);
         tests_run++;
         if (press1 !== exp_p[i] || held1 !== seq[i] || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL immediate edge %0d got p=%b h=%b b=%b want p=%b h=%b b=0",
                     i + 1, press1, held1, busy1, exp_p[i], seq[i]);
         end
      end
   endtask

   task automatic test_random();
      logic k = 1'b0;
      logic prev4 = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) < 30) k = ~k;
         tick(k, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
         tests_run++;
         if ({press4, held4, busy4} !== {m4_p, m4_h, m4_b} ||
             {press1, held1, busy1} !== {m1_p, m1_h, m1_b} || (prev4 && press4)) begin
            failures++;
            $display("FAIL random step %0d got %b%b%b %b%b%b want %b%b%b %b%b%b", i,
                     press4, held4, busy4, press1, held1, busy1,
                     m4_p, m4_h, m4_b, m1_p, m1_h, m1_b);
         end
         prev4 = press4;
      end
   endtask

   initial begin
      key = 1'b0; en = 1'b0; reset = 1'b1;
      m4_h = 1'b0; m4_p = 1'b0; m4_b = 1'b0; m4_run = 0;
      m1_h = 1'b0; m1_p = 1'b0; m1_b = 1'b0; m1_run = 0;
      test_reset();
      test_clean_press();
      test_press_bounce();
      test_release_bounce();
      test_en_gating();
      test_reset_mid_hold();
      test_immediate();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
